// File: rtl/decoder_host_if.sv
// Host-side adapter for the min-sum decoder: chunked LLR frame load, result request and codeword reassembly.
// Optional watchdog on the result path is built in when DEC_HOST_WDOG_EN is defined.
module decoder_host_if #(
    parameter int WIDTH_IN    = 6,
    parameter int N_LLRS      = 4,
    parameter int WIDTH_OUT   = 4,
    parameter int N_V         = 10,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WIDTH_IN*N_V-1:0]     frame_llrs,
    input  logic                        frame_valid,
    output logic                        frame_ready,
    output logic [N_V-1:0]              cw_out,
    output logic                        cw_valid,
    input  logic                        cw_ready,
    output logic [N_LLRS*WIDTH_IN-1:0]  dec_databus_in,
    output logic                        dec_first_data,
    output logic                        dec_data_valid,
    output logic                        dec_first_data_out,
    input  logic [WIDTH_OUT-1:0]        dec_databus_out,
    input  logic                        dec_data_valid_out,
    input  logic                        dec_out_ready,
    input  logic                        dec_busy,
    output logic                        err
);

    localparam int FRAME_W         = WIDTH_IN * N_V;
    localparam int CHUNK_W         = N_LLRS * WIDTH_IN;
    localparam int L_SEG           = (N_V - 1) / N_LLRS;
    localparam int FIRST_CHUNK     = ((N_V - 1) % N_LLRS + 1) * WIDTH_IN;
    localparam int L_SEG_OUT       = (N_V - 1) / WIDTH_OUT;
    localparam int FIRST_CHUNK_OUT = (N_V - 1) % WIDTH_OUT + 1;
    localparam int SEG_CNT_W       = $clog2(L_SEG + 2);
    localparam int WORD_CNT_W      = $clog2(L_SEG_OUT + 2);

    localparam logic [SEG_CNT_W-1:0]  SEG_LAST  = SEG_CNT_W'(L_SEG);
    localparam logic [WORD_CNT_W-1:0] WORD_LAST = WORD_CNT_W'(L_SEG_OUT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_F,
        ST_SEND,
        ST_WAIT_RDY,
        ST_RECV,
        ST_HOLD
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [FRAME_W-1:0]     llr_shift;
    logic [SEG_CNT_W-1:0]   seg_cnt;
    logic [WORD_CNT_W-1:0]  word_cnt;
    logic [N_V-1:0]         cw_shift;
    logic [N_V-1:0]         cw_next;
    logic                   timeout;

    // Word 0 carries only the top FIRST_CHUNK_OUT codeword bits; its upper bits are don't-care.
    function automatic logic [N_V-1:0] merge_word(input logic             first,
                                                  input logic [N_V-1:0]   acc,
                                                  input logic [WIDTH_OUT-1:0] word);
        if (first) begin
            return N_V'(word[FIRST_CHUNK_OUT-1:0]);
        end
        return (acc << WIDTH_OUT) | N_V'(word);
    endfunction

    assign cw_next = merge_word(word_cnt == '0, cw_shift, dec_databus_out);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt          = state;
        frame_ready        = 1'b0;
        dec_first_data     = 1'b0;
        dec_data_valid     = 1'b0;
        dec_databus_in     = '0;
        dec_first_data_out = 1'b0;
        case (state)
            ST_IDLE: begin
                frame_ready = rst;
                if (frame_valid && frame_ready) begin
                    state_nxt = ST_SEND_F;
                end
            end
            ST_SEND_F: begin
                if (!dec_busy) begin
                    dec_first_data                   = 1'b1;
                    dec_data_valid                   = 1'b1;
                    dec_databus_in[FIRST_CHUNK-1:0]  = llr_shift[FRAME_W-1 -: FIRST_CHUNK];
                    state_nxt = (L_SEG == 0) ? ST_WAIT_RDY : ST_SEND;
                end
            end
            ST_SEND: begin
                dec_data_valid = 1'b1;
                dec_databus_in = llr_shift[FRAME_W-1 -: CHUNK_W];
                if (seg_cnt == SEG_LAST) begin
                    state_nxt = ST_WAIT_RDY;
                end
            end
            ST_WAIT_RDY: begin
                if (dec_out_ready) begin
                    dec_first_data_out = 1'b1;
                    state_nxt          = ST_RECV;
                end else if (timeout) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (dec_data_valid_out) begin
                    if (word_cnt == WORD_LAST) begin
                        state_nxt = ST_HOLD;
                    end
                end else if (timeout) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (cw_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Load path: the frame is consumed MSB-first, so the top of the shift register is always the next chunk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            llr_shift <= '0;
            seg_cnt   <= '0;
            word_cnt  <= '0;
            cw_shift  <= '0;
            cw_out    <= '0;
            cw_valid  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (frame_valid && frame_ready) begin
                        llr_shift <= frame_llrs;
                        seg_cnt   <= '0;
                    end
                end
                ST_SEND_F: begin
                    if (!dec_busy) begin
                        llr_shift <= llr_shift << FIRST_CHUNK;
                        seg_cnt   <= SEG_CNT_W'(1);
                    end
                end
                ST_SEND: begin
                    llr_shift <= llr_shift << CHUNK_W;
                    seg_cnt   <= seg_cnt + SEG_CNT_W'(1);
                end
                ST_WAIT_RDY: begin
                    if (dec_out_ready) begin
                        word_cnt <= '0;
                    end
                end
                ST_RECV: begin
                    if (dec_data_valid_out) begin
                        cw_shift <= cw_next;
                        word_cnt <= word_cnt + WORD_CNT_W'(1);
                        if (word_cnt == WORD_LAST) begin
                            cw_out   <= cw_next;
                            cw_valid <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (cw_ready) begin
                        cw_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DEC_HOST_WDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_run;

    assign wd_run  = (state == ST_WAIT_RDY) || (state == ST_RECV);
    assign timeout = wd_run && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

    // Restarts on entering WAIT_RDY/RECV and on every received word; only a timeout leads back to IDLE from here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt <= '0;
            err    <= 1'b0;
        end else begin
            if (!wd_run || (state_nxt != state) || ((state == ST_RECV) && dec_data_valid_out)) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
            if (wd_run && (state_nxt == ST_IDLE)) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;

    // TIMEOUT_CYC has no effect without the watchdog.
    if (TIMEOUT_CYC < 1) begin : g_wdog_limit_unused
    end
`endif

endmodule
